// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES128 core between two requesters; one job in flight,
// response CORE_LATENCY+2 cycles after accept; a stalled response blocks all new accepts.
module aes_job_arbiter #(
    parameter int CORE_LATENCY = 12,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_decrypt,
    input  logic [127:0]     req0_data,
    input  logic [127:0]     req0_key,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_decrypt,
    input  logic [127:0]     req1_data,
    input  logic [127:0]     req1_key,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [127:0]     rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [127:0]     rsp1_data,
    output logic             core_start,
    output logic             core_selCypher,
    output logic [127:0]     core_message,
    output logic [127:0]     core_key,
    input  logic [127:0]     core_message_out,
    output logic             busy,
    output logic             grant_id,
    output logic [CNT_W-1:0] done_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [4:0] WAIT_LOAD = 5'(CORE_LATENCY - 1);

    state_t           state_q, state_d;
    logic [127:0]     msg_q, msg_d;
    logic [127:0]     key_q, key_d;
    logic [127:0]     result_q, result_d;
    logic             dec_q, dec_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic [1:0]       rsp_vld_q, rsp_vld_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic             idle;
    logic             rsp_hs;

    assign idle = (state_q == IDLE);

    // On a tie the requester not granted last wins; last_q resets to 1 so req0 takes the first tie.
    assign req0_ready = idle & req0_valid & (~req1_valid | last_q);
    assign req1_ready = idle & req1_valid & (~req0_valid | ~last_q);
    assign rsp_hs     = (rsp_vld_q[0] & rsp0_ready) | (rsp_vld_q[1] & rsp1_ready);

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        key_d    = key_q;
        dec_d    = dec_q;
        grant_d  = grant_q;
        last_d   = last_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        start_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_ready | req1_ready) begin
                    msg_d   = req1_ready ? req1_data    : req0_data;
                    key_d   = req1_ready ? req1_key     : req0_key;
                    dec_d   = req1_ready ? req1_decrypt : req0_decrypt;
                    grant_d = req1_ready;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = WAIT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 5'd0) begin
                    result_d = core_message_out;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    last_d  = grant_q;
                    done_d  = done_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        rsp_vld_d = {(state_d == RESP) & grant_d, (state_d == RESP) & ~grant_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            msg_q     <= '0;
            key_q     <= '0;
            dec_q     <= 1'b0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            result_q  <= '0;
            cnt_q     <= '0;
            done_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            rsp_vld_q <= '0;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            key_q     <= key_d;
            dec_q     <= dec_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    assign core_start     = start_q;
    assign core_selCypher = dec_q;
    assign core_message   = msg_q;
    assign core_key       = key_q;
    assign rsp0_valid     = rsp_vld_q[0];
    assign rsp1_valid     = rsp_vld_q[1];
    // Both ports carry the result; only the granted port's valid qualifies it.
    assign rsp0_data      = result_q;
    assign rsp1_data      = result_q;
    assign busy           = busy_q;
    assign grant_id       = grant_q;
    assign done_count     = done_q;
endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter with a latency-exact AES core stand-in and a response scoreboard.
module tb_aes_job_arbiter;
    localparam int LAT = 12;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct packed {
        logic         port;
        logic [127:0] data;
    } sb_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req0_decrypt;
    logic [127:0] req0_data, req0_key;
    logic         req1_valid, req1_ready, req1_decrypt;
    logic [127:0] req1_data, req1_key;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [127:0] rsp0_data, rsp1_data;
    logic         core_start, core_selCypher;
    logic [127:0] core_message, core_key, core_message_out;
    logic         busy, grant_id;
    logic [3:0]   done_count;

    int  n_asserts = 0;
    int  n_fail    = 0;
    int  n_pops    = 0;
    sb_t sb_q[$];
    logic [7:0] grant_hist;

    int  core_age = 0;
    bit  core_active = 1'b0;

    aes_job_arbiter #(.CORE_LATENCY(LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_decrypt(req0_decrypt),
        .req0_data(req0_data), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_decrypt(req1_decrypt),
        .req1_data(req1_data), .req1_key(req1_key),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .core_start(core_start), .core_selCypher(core_selCypher),
        .core_message(core_message), .core_key(core_key), .core_message_out(core_message_out),
        .busy(busy), .grant_id(grant_id), .done_count(done_count)
    );

    always #5 clk = ~clk;

    // Known AES-128 vector in both directions; any other job gets a cheap reversible stand-in.
    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input logic dec);
        if (!dec && d == PT && k == KEY) return CT;
        if (dec && d == CT && k == KEY) return PT;
        return d ^ {k[63:0], k[127:64]} ^ {128{dec}};
    endfunction

    // Core stand-in: the correct result is present only in the cycle LAT after the start cycle.
    always @(negedge clk) begin
        if (reset) begin
            core_active = 1'b0;
            core_age    = 0;
        end else if (core_start) begin
            core_active = 1'b1;
            core_age    = 0;
        end else if (core_active) begin
            core_age++;
        end
        if (core_active && core_age == LAT)
            core_message_out = model(core_message, core_key, core_selCypher);
        else
            core_message_out = ~model(core_message, core_key, core_selCypher);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input logic port);
        int  n;
        sb_t e;
        n = sb_q.size();
        chk("sb_depth", 128'(n), 128'd1);
        if (n > 0) begin
            e = sb_q.pop_front();
            n_pops++;
            chk("rsp_port", 128'(port), 128'(e.port));
            chk("rsp_data", port ? rsp1_data : rsp0_data, e.data);
        end
    endtask

    // Called once per cycle before the edge: records accepts and checks completed responses.
    task automatic observe();
        sb_t e;
        #1;
        if (req0_valid && req0_ready) begin
            e.port = 1'b0;
            e.data = model(req0_data, req0_key, req0_decrypt);
            sb_q.push_back(e);
            grant_hist = {grant_hist[6:0], 1'b0};
        end
        if (req1_valid && req1_ready) begin
            e.port = 1'b1;
            e.data = model(req1_data, req1_key, req1_decrypt);
            sb_q.push_back(e);
            grant_hist = {grant_hist[6:0], 1'b1};
        end
        if (rsp0_valid && rsp0_ready) pop_check(1'b0);
        if (rsp1_valid && rsp1_ready) pop_check(1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sb_q.delete();
        grant_hist = '0;
    endtask

    task automatic set_req(input logic port, input logic v, input logic dec, input logic [127:0] d,
                           input logic [127:0] k);
        if (port) begin
            req1_valid = v; req1_decrypt = dec; req1_data = d; req1_key = k;
        end else begin
            req0_valid = v; req0_decrypt = dec; req0_data = d; req0_key = k;
        end
    endtask

    // Runs one job on a port; returns in the first cycle its response is valid.
    task automatic go(input logic port, input logic dec, input logic [127:0] d, input logic [127:0] k);
        int lat, st_at, st_n;
        bit acc, opbad, gbad;
        acc = 1'b0;
        set_req(port, 1'b1, dec, d, k);
        for (int n = 0; n < 50; n++) begin
            observe();
            if (port ? req1_ready : req0_ready) begin
                acc = 1'b1;
                break;
            end
            tick();
        end
        chk("accept", 128'(acc), 128'd1);
        if (acc) begin
            tick();
            set_req(port, 1'b0, dec, d, k);
            lat = 1; st_at = -1; st_n = 0; opbad = 1'b0; gbad = 1'b0;
            while (!(port ? rsp1_valid : rsp0_valid) && lat < 100) begin
                if (core_start) begin
                    st_n++;
                    if (st_at < 0) st_at = lat;
                end
                if (core_message !== d || core_key !== k || core_selCypher !== dec || busy !== 1'b1) opbad = 1'b1;
                if (grant_id !== port) gbad = 1'b1;
                observe();
                tick();
                lat++;
            end
            chk("rsp_latency", 128'(lat), 128'(LAT + 2));
            chk("start_cycle", 128'(st_at), 128'd1);
            chk("start_pulses", 128'(st_n), 128'd1);
            chk("operands_stable", 128'(opbad), 128'd0);
            chk("grant_id", 128'(gbad), 128'd0);
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp0_valid && !rsp1_valid && n < 100) begin
            observe();
            tick();
            n++;
        end
        chk("rsp_wait", 128'(n < 100), 128'd1);
        observe();
        tick();
    endtask

    initial begin
        logic [127:0] exp_d;
        logic [3:0]   done_before;
        int  nrsp;
        bit  flag_a, flag_b;

        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        do_reset();

        // Reset state
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done_count), 128'd0);
        chk("rst_rsp_valid", 128'({rsp1_valid, rsp0_valid}), 128'd0);
        chk("rst_core_start", 128'(core_start), 128'd0);
        chk("rst_core_message", core_message, 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_rsp_data", rsp0_data, 128'd0);
        chk("rst_grant", 128'(grant_id), 128'd0);

        // Single encrypt job on port 0
        go(1'b0, 1'b0, PT, KEY);
        chk("single_rsp0_data", rsp0_data, CT);
        chk("single_rsp1_valid", 128'(rsp1_valid), 128'd0);
        observe();
        tick();
        chk("single_done", 128'(done_count), 128'd1);
        chk("single_idle", 128'(busy), 128'd0);

        // Contention from reset: both requesters held valid
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 128'h0123456789abcdef0011223344556677, 128'hffeeddccbbaa99887766554433221100);
        set_req(1'b1, 1'b1, 1'b0, 128'hcafef00ddeadbeef0badc0de12345678, 128'h13579bdf2468ace0fedcba9876543210);
        nrsp = 0;
        flag_a = 1'b0;
        for (int c = 0; c < 400 && nrsp < 4; c++) begin
            if (rsp0_valid || rsp1_valid) begin
                nrsp++;
                if ((rsp0_valid && rsp1_valid) || grant_id !== rsp1_valid) flag_a = 1'b1;
                if (nrsp == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
            observe();
            tick();
        end
        chk("cont_responses", 128'(nrsp), 128'd4);
        chk("cont_own_port", 128'(flag_a), 128'd0);
        chk("cont_grant_order", 128'(grant_hist[3:0]), 128'(4'b0101));
        chk("cont_done", 128'(done_count), 128'd4);
        chk("cont_idle", 128'(busy), 128'd0);

        // Backpressure: rsp1 stalled 20 cycles while req0 waits
        rsp1_ready = 1'b0;
        go(1'b1, 1'b0, 128'h00000000111111112222222233333333, 128'h44444444555555556666666677777777);
        exp_d = model(128'h00000000111111112222222233333333, 128'h44444444555555556666666677777777, 1'b0);
        set_req(1'b0, 1'b1, 1'b0, 128'h8899aabbccddeeff0011223344556677, KEY);
        done_before = done_count;
        flag_a = 1'b0;
        flag_b = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || busy !== 1'b1 || rsp1_data !== exp_d) flag_a = 1'b1;
            if (req0_ready !== 1'b0 || done_count !== done_before) flag_b = 1'b1;
            observe();
            tick();
        end
        chk("bp_stall_resp", 128'(flag_a), 128'd0);
        chk("bp_no_accept", 128'(flag_b), 128'd0);
        rsp1_ready = 1'b1;
        observe();
        tick();
        observe();
        chk("bp_accept_after_hs", 128'(req0_ready), 128'd1);
        chk("bp_idle_after_hs", 128'(busy), 128'd0);
        tick();
        req0_valid = 1'b0;
        chk("bp_core_start", 128'(core_start), 128'd1);
        wait_rsp();
        chk("bp_done", 128'(done_count), 128'd6);

        // Decrypt on port 1
        go(1'b1, 1'b1, CT, KEY);
        chk("dec_selCypher", 128'(core_selCypher), 128'd1);
        chk("dec_rsp1_data", rsp1_data, PT);
        chk("dec_rsp0_valid", 128'(rsp0_valid), 128'd0);
        observe();
        tick();
        chk("dec_done", 128'(done_count), 128'd7);

        // Reset in the middle of WAIT
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, PT, KEY);
        observe();
        tick();
        req0_valid = 1'b0;
        chk("abort_start", 128'(core_start), 128'd1);
        repeat (5) tick();
        chk("abort_pre_busy", 128'(busy), 128'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_rsp_valid", 128'({rsp1_valid, rsp0_valid}), 128'd0);
        chk("abort_done", 128'(done_count), 128'd0);
        chk("abort_core_message", core_message, 128'd0);
        chk("abort_core_key", core_key, 128'd0);
        chk("abort_selCypher", 128'(core_selCypher), 128'd0);
        flag_a = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rsp0_valid || rsp1_valid || busy) flag_a = 1'b1;
            observe();
            tick();
        end
        chk("abort_quiet", 128'(flag_a), 128'd0);

        // done_count wrap with a 4-bit counter
        for (int j = 0; j < 17; j++) begin
            go(j[0], 1'b0, {4{32'(j)}}, ~{4{32'(j * 7 + 3)}});
            observe();
            tick();
            if (j == 15) chk("wrap_16_jobs", 128'(done_count), 128'd0);
        end
        chk("wrap_17_jobs", 128'(done_count), 128'd1);
        chk("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
